dp_mem_responder: RTL and testbench



---
 rtl/dp_mem_responder_if.sv | 44 ++++
 rtl/dp_mem_responder.sv | 203 ++++++++++++++++++++
 tb/tb_dp_mem_responder.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/dp_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : dp_mem_responder_if
// Brief    : Datapath request/response and RAM port bundle for dp_mem_responder.
// Revision : 1.0
// ============================================================================
interface dp_mem_responder_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              halt;
  logic              imemREN;
  logic [ADDR_W-1:0] imemaddr;
  logic              dmemREN;
  logic              dmemWEN;
  logic [ADDR_W-1:0] dmemaddr;
  logic [DATA_W-1:0] dmemstore;
  logic              ihit;
  logic [DATA_W-1:0] imemload;
  logic              dhit;
  logic [DATA_W-1:0] dmemload;
  logic              ram_ren;
  logic              ram_wen;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_store;
  logic [DATA_W-1:0] ram_load;
  logic              ram_ready;
  logic              err;

  modport slave (
    input  halt, imemREN, imemaddr, dmemREN, dmemWEN, dmemaddr, dmemstore,
           ram_load, ram_ready,
    output ihit, imemload, dhit, dmemload, ram_ren, ram_wen, ram_addr,
           ram_store, err
  );

  modport master (
    output halt, imemREN, imemaddr, dmemREN, dmemWEN, dmemaddr, dmemstore,
           ram_load, ram_ready,
    input  ihit, imemload, dhit, dmemload, ram_ren, ram_wen, ram_addr,
           ram_store, err
  );
endinterface
`default_nettype wire

// File: rtl/dp_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dp_mem_responder
// Brief    : Arbitrates datapath fetch/load/store requests onto one RAM port and
//            returns single-cycle hits. Macro IFETCH_BUF_EN adds a one-entry
//            instruction fetch buffer.
// Revision : 1.0
// ============================================================================
module dp_mem_responder #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              CLK,
  input  logic              RST,
  dp_mem_responder_if.slave bus
);

  localparam int                  c_CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_CNT_W-1:0]  c_CNT_LAST = c_CNT_W'(TIMEOUT - 2);
  localparam logic [DATA_W-1:0]   c_BAD_DATA = DATA_W'(32'hBAD1_BAD1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DBUSY = 2'd1,
    S_IBUSY = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   store_q, store_d;
  logic                wr_q, wr_d;
  logic [c_CNT_W-1:0]  cnt_q, cnt_d;
  logic                ihit_q, ihit_d;
  logic                dhit_q, dhit_d;
  logic [DATA_W-1:0]   imemload_q, imemload_d;
  logic [DATA_W-1:0]   dmemload_q, dmemload_d;
  logic                err_q, err_d;
  logic                w_ram_ren;
  logic                w_ram_wen;

`ifdef IFETCH_BUF_EN
  logic                buf_valid_q, buf_valid_d;
  logic [ADDR_W-3:0]   buf_tag_q, buf_tag_d;
  logic [DATA_W-1:0]   buf_data_q, buf_data_d;
`endif

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    store_d    = store_q;
    wr_d       = wr_q;
    cnt_d      = cnt_q;
    ihit_d     = 1'b0;
    dhit_d     = 1'b0;
    imemload_d = imemload_q;
    dmemload_d = dmemload_q;
    err_d      = err_q;
    w_ram_ren  = 1'b0;
    w_ram_wen  = 1'b0;
`ifdef IFETCH_BUF_EN
    buf_valid_d = buf_valid_q;
    buf_tag_d   = buf_tag_q;
    buf_data_d  = buf_data_q;
`endif

    case (state_q)
      S_IDLE: begin
        // Data requests win; a simultaneous load+store is handled as a store.
        if (bus.dmemREN || bus.dmemWEN) begin
          addr_d  = bus.dmemaddr;
          store_d = bus.dmemstore;
          wr_d    = bus.dmemWEN;
          cnt_d   = '0;
          state_d = S_DBUSY;
`ifdef IFETCH_BUF_EN
          if (bus.dmemWEN && (buf_tag_q == bus.dmemaddr[ADDR_W-1:2]))
            buf_valid_d = 1'b0;
`endif
        end else if (bus.imemREN && !bus.halt) begin
`ifdef IFETCH_BUF_EN
          if (buf_valid_q && (buf_tag_q == bus.imemaddr[ADDR_W-1:2])) begin
            ihit_d     = 1'b1;
            imemload_d = buf_data_q;
            state_d    = S_RESP;
          end else begin
            addr_d  = bus.imemaddr;
            wr_d    = 1'b0;
            cnt_d   = '0;
            state_d = S_IBUSY;
          end
`else
          addr_d  = bus.imemaddr;
          wr_d    = 1'b0;
          cnt_d   = '0;
          state_d = S_IBUSY;
`endif
        end
      end

      S_DBUSY: begin
        w_ram_wen = wr_q;
        w_ram_ren = !wr_q;
        if (bus.ram_ready) begin
          dhit_d     = 1'b1;
          dmemload_d = wr_q ? '0 : bus.ram_load;
          state_d    = S_RESP;
        end else begin
          cnt_d = cnt_q + c_CNT_W'(1);
          if (cnt_q == c_CNT_LAST) begin
            err_d      = 1'b1;
            dhit_d     = 1'b1;
            dmemload_d = c_BAD_DATA;
            state_d    = S_RESP;
          end
        end
      end

      S_IBUSY: begin
        w_ram_ren = 1'b1;
        if (bus.ram_ready) begin
          ihit_d     = 1'b1;
          imemload_d = bus.ram_load;
          state_d    = S_RESP;
`ifdef IFETCH_BUF_EN
          buf_valid_d = 1'b1;
          buf_tag_d   = addr_q[ADDR_W-1:2];
          buf_data_d  = bus.ram_load;
`endif
        end else begin
          cnt_d = cnt_q + c_CNT_W'(1);
          if (cnt_q == c_CNT_LAST) begin
            err_d      = 1'b1;
            ihit_d     = 1'b1;
            imemload_d = c_BAD_DATA;
            state_d    = S_RESP;
          end
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      store_q    <= '0;
      wr_q       <= 1'b0;
      cnt_q      <= '0;
      ihit_q     <= 1'b0;
      dhit_q     <= 1'b0;
      imemload_q <= '0;
      dmemload_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      store_q    <= store_d;
      wr_q       <= wr_d;
      cnt_q      <= cnt_d;
      ihit_q     <= ihit_d;
      dhit_q     <= dhit_d;
      imemload_q <= imemload_d;
      dmemload_q <= dmemload_d;
      err_q      <= err_d;
    end
  end

`ifdef IFETCH_BUF_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      buf_valid_q <= 1'b0;
      buf_tag_q   <= '0;
      buf_data_q  <= '0;
    end else begin
      buf_valid_q <= buf_valid_d;
      buf_tag_q   <= buf_tag_d;
      buf_data_q  <= buf_data_d;
    end
  end
`endif

  assign bus.ihit      = ihit_q;
  assign bus.dhit      = dhit_q;
  assign bus.imemload  = imemload_q;
  assign bus.dmemload  = dmemload_q;
  assign bus.err       = err_q;
  assign bus.ram_ren   = w_ram_ren;
  assign bus.ram_wen   = w_ram_wen;
  assign bus.ram_addr  = addr_q & ~ADDR_W'(3);
  assign bus.ram_store = store_q;

endmodule
`default_nettype wire

// File: tb/tb_dp_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dp_mem_responder
// Brief    : Self-checking bench for dp_mem_responder with a RAM and hit-timing
//            reference model; follows IFETCH_BUF_EN when defined.
// Revision : 1.0
// ============================================================================
module tb_dp_mem_responder;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 64;
`ifdef IFETCH_BUF_EN
  localparam bit c_BUF_EN = 1'b1;
`else
  localparam bit c_BUF_EN = 1'b0;
`endif
  localparam logic [31:0] c_BAD = 32'hBAD1_BAD1;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  dp_mem_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  dp_mem_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] mem [logic [31:0]];
  bit          err_exp;
  bit          buf_v;
  logic [29:0] buf_tag;
  logic [31:0] buf_d;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'hA5A5_5A5A;
  endfunction

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic do_reset(input int n);
    RST           = 1'b1;
    bus.imemREN   = 1'b0;
    bus.dmemREN   = 1'b0;
    bus.dmemWEN   = 1'b0;
    bus.halt      = 1'b0;
    bus.ram_ready = 1'b0;
    repeat (n) step();
    RST     = 1'b0;
    err_exp = 1'b0;
    buf_v   = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "/ihit"},      32'(bus.ihit),    32'd0);
    check({tag, "/dhit"},      32'(bus.dhit),    32'd0);
    check({tag, "/ram_ren"},   32'(bus.ram_ren), 32'd0);
    check({tag, "/ram_wen"},   32'(bus.ram_wen), 32'd0);
    check({tag, "/err"},       32'(bus.err),     32'd0);
    check({tag, "/imemload"},  bus.imemload,     32'd0);
    check({tag, "/dmemload"},  bus.dmemload,     32'd0);
    check({tag, "/ram_addr"},  bus.ram_addr,     32'd0);
    check({tag, "/ram_store"}, bus.ram_store,    32'd0);
  endtask

  // One request from issue to hit; k is the strobe cycle on which the RAM answers.
  task automatic txn(input bit is_d, input bit ren, input bit wen, input logic [31:0] addr,
                     input logic [31:0] sdata, input int k, input string tag);
    logic [31:0] al, exp_data;
    int          exp_lat, cyc, strobes;
    bit          done, timed, bhit, exp_wr;
    al      = addr & ~32'd3;
    exp_wr  = is_d && wen;
    bhit    = !is_d && c_BUF_EN && buf_v && (buf_tag == addr[31:2]);
    timed   = !bhit && (k >= TIMEOUT);
    exp_lat = bhit ? 1 : (timed ? TIMEOUT : k + 1);
    if (bhit)        exp_data = buf_d;
    else if (timed)  exp_data = c_BAD;
    else if (exp_wr) exp_data = 32'd0;
    else             exp_data = mem_rd(al);
    if (exp_wr && buf_v && (buf_tag == addr[31:2])) buf_v = 1'b0;

    if (is_d) begin
      bus.dmemREN   = ren;
      bus.dmemWEN   = wen;
      bus.dmemaddr  = addr;
      bus.dmemstore = sdata;
    end else begin
      bus.imemREN  = 1'b1;
      bus.imemaddr = addr;
      bus.halt     = 1'b0;
    end
    bus.ram_ready = 1'b0;
    cyc = 0; strobes = 0; done = 1'b0;
    while (!done && cyc < 4 * TIMEOUT) begin
      step();
      cyc++;
      if (bus.ihit || bus.dhit) begin
        done = 1'b1;
      end else begin
        bus.ram_ready = 1'b0;
        bus.ram_load  = $urandom();
        if (bus.ram_ren || bus.ram_wen) begin
          strobes++;
          if (strobes == 1) begin
            check({tag, "/ram_addr"}, bus.ram_addr, al);
            check({tag, "/ram_wen"},  32'(bus.ram_wen), 32'(exp_wr));
            check({tag, "/ram_ren"},  32'(bus.ram_ren), 32'(!exp_wr));
            if (exp_wr) check({tag, "/ram_store"}, bus.ram_store, sdata);
          end
          // An in-flight fetch must ignore halt.
          if (!is_d) bus.halt = 1'($urandom_range(0, 1));
          if (strobes == k) begin
            bus.ram_ready = 1'b1;
            if (exp_wr) mem[bus.ram_addr] = sdata;
            else        bus.ram_load = mem_rd(bus.ram_addr);
          end
        end
      end
    end
    check({tag, "/completed"}, 32'(done), 32'd1);
    check({tag, "/latency"},   32'(cyc), 32'(exp_lat));
    check({tag, "/hit_sel"},   {30'd0, bus.ihit, bus.dhit}, is_d ? 32'd1 : 32'd2);
    check({tag, "/load"},      is_d ? bus.dmemload : bus.imemload, exp_data);
    check({tag, "/strobes"},   32'(strobes), 32'(exp_lat - 1));
    check({tag, "/resp_strb"}, {30'd0, bus.ram_ren, bus.ram_wen}, 32'd0);
    if (timed) err_exp = 1'b1;
    check({tag, "/err"},       32'(bus.err), 32'(err_exp));
    if (!is_d && !bhit && !timed) begin
      buf_v   = 1'b1;
      buf_tag = addr[31:2];
      buf_d   = exp_data;
    end

    if (is_d) begin
      bus.dmemREN = 1'b0;
      bus.dmemWEN = 1'b0;
    end else begin
      bus.imemREN = 1'b0;
    end
    bus.halt      = 1'b0;
    bus.ram_ready = 1'b0;
    step();
    check({tag, "/one_pulse"}, {30'd0, bus.ihit, bus.dhit}, 32'd0);
  endtask

  initial begin
    bit          act;
    int          kind, k;
    logic [31:0] a;

    bus.halt = 1'b0;     bus.imemREN = 1'b0; bus.imemaddr = '0;
    bus.dmemREN = 1'b0;  bus.dmemWEN = 1'b0; bus.dmemaddr = '0;
    bus.dmemstore = '0;  bus.ram_load = '0;  bus.ram_ready = 1'b0;
    RST = 1'b1;
    @(negedge CLK);
    do_reset(2);
    check_quiet("reset");

    mem[32'h4]   = 32'h3C01_0001;
    mem[32'h100] = 32'hDEAD_BEEF;
    txn(1'b0, 1'b0, 1'b0, 32'h0000_0004, 32'd0, 2, "fetch");

    bus.imemREN  = 1'b1;
    bus.imemaddr = 32'h10;
    txn(1'b1, 1'b1, 1'b0, 32'h0000_0103, 32'd0, 3, "arb_d");
    txn(1'b0, 1'b0, 1'b0, 32'h0000_0010, 32'd0, 1, "arb_i");

    txn(1'b1, 1'b0, 1'b1, 32'h0000_0200, 32'h1234_5678, 2, "store");
    txn(1'b1, 1'b1, 1'b0, 32'h0000_0202, 32'd0, 1, "store_rb");
    txn(1'b1, 1'b1, 1'b1, 32'h0000_0208, 32'hCAFE_F00D, 1, "ren_wen");
    txn(1'b1, 1'b1, 1'b0, 32'h0000_0208, 32'd0, 4, "ren_wen_rb");

    txn(1'b0, 1'b0, 1'b0, 32'h0000_0040, 32'd0, 2, "buf_f1");
    txn(1'b0, 1'b0, 1'b0, 32'h0000_0040, 32'd0, 2, "buf_f2");
    txn(1'b1, 1'b0, 1'b1, 32'h0000_0040, 32'h0BAD_CAFE, 1, "buf_st");
    txn(1'b0, 1'b0, 1'b0, 32'h0000_0040, 32'd0, 2, "buf_f3");

    bus.halt     = 1'b1;
    bus.imemREN  = 1'b1;
    bus.imemaddr = 32'h80;
    act = 1'b0;
    repeat (6) begin
      step();
      if (bus.ram_ren || bus.ram_wen || bus.ihit || bus.dhit) act = 1'b1;
    end
    check("halt/blocked", 32'(act), 32'd0);
    txn(1'b0, 1'b0, 1'b0, 32'h0000_0080, 32'd0, 2, "halt_rel");
    bus.halt = 1'b1;
    txn(1'b1, 1'b1, 1'b0, 32'h0000_0100, 32'd0, 2, "halt_load");

    for (int i = 0; i < 30; i++) begin
      kind = $urandom_range(0, 3);
      a    = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      k    = $urandom_range(1, 6);
      txn(kind != 0, (kind == 1) || (kind == 3), kind >= 2, a, $urandom(), k, "rand");
    end

    txn(1'b1, 1'b1, 1'b0, 32'h0000_0300, 32'd0, TIMEOUT - 1, "last_ok");
    txn(1'b1, 1'b1, 1'b0, 32'h0000_0304, 32'd0, TIMEOUT + 20, "tmo_d");
    txn(1'b0, 1'b0, 1'b0, 32'h0000_0308, 32'd0, 2, "sticky");
    txn(1'b0, 1'b0, 1'b0, 32'h0000_030C, 32'd0, TIMEOUT + 5, "tmo_i");

    bus.imemREN  = 1'b1;
    bus.imemaddr = 32'h0000_0310;
    repeat (3) step();
    check("midrst/busy", 32'(bus.ram_ren), 32'd1);
    do_reset(1);
    check_quiet("midrst");
    step();
    check("midrst/nohit", {30'd0, bus.ihit, bus.dhit}, 32'd0);
    txn(1'b0, 1'b0, 1'b0, 32'h0000_0310, 32'd0, 3, "after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
